// File: rtl/mapeamento_tecla_cp_oct.sv
// mapeamento_tecla_cp_oct
//   Keyboard front end for the synth. Each raw key line and each octave button
//   is synchronised and debounced. The lowest-index held key is selected and
//   mapped to an oscillator half-period, and an octave shift is applied.
//   Outputs are registered.
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active high
//   teclas     raw key lines, 1 = pressed (asynchronous)
//   oct_sobe   raw octave-up button (asynchronous)
//   oct_desce  raw octave-down button (asynchronous)
//   cp         oscillator half-period count
//   gate       1 while any debounced key is held
//   nova_nota  one-cycle strobe on note start or note change
//   nota_idx   index of the selected key
//   oitava     current octave

// Per-input lane: 2-flop synchroniser plus debounce counter. The accepted
// (debounced) value is held by the caller and fed back in on deb. deb_nxt
// is the value it takes at the next edge, so a caller can act in the same
// edge as the flip.
module debounce_lane #(
    parameter int unsigned DEBOUNCE_CICLOS = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic deb,
    output logic deb_nxt
);
    localparam int unsigned CW = (DEBOUNCE_CICLOS < 2) ? 1 : $clog2(DEBOUNCE_CICLOS);

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          ultimo;

    // The counter never holds DEBOUNCE_CICLOS: the step that would reach it flips instead.
    assign ultimo  = (cnt == CW'(DEBOUNCE_CICLOS - 1));
    assign deb_nxt = (s2 != deb && ultimo) ? ~deb : deb;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == deb || ultimo) cnt <= '0;
            else                     cnt <= cnt + 1'b1;
        end
    end
endmodule

module mapeamento_tecla_cp_oct #(
    parameter int unsigned NR_TECLAS       = 12,
    parameter int unsigned NR_OITAVAS      = 4,
    parameter int unsigned OITAVA_INICIAL  = 0,
    parameter int unsigned DEBOUNCE_CICLOS = 500000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NR_TECLAS-1:0] teclas,
    input  logic                 oct_sobe,
    input  logic                 oct_desce,
    output logic [17:0]          cp,
    output logic                 gate,
    output logic                 nova_nota,
    output logic [3:0]           nota_idx,
    output logic [1:0]           oitava
);
    localparam logic [1:0] OIT_MAX = 2'(NR_OITAVAS - 1);
    localparam logic [1:0] OIT_INI = 2'(OITAVA_INICIAL);

    typedef enum logic {IDLE, HELD} botao_t;

    function automatic logic [17:0] tabela(input logic [3:0] i);
        case (i)
            4'd0:    tabela = 18'd143172;
            4'd1:    tabela = 18'd135139;
            4'd2:    tabela = 18'd127551;
            4'd3:    tabela = 18'd120394;
            4'd4:    tabela = 18'd113636;
            4'd5:    tabela = 18'd107262;
            4'd6:    tabela = 18'd101239;
            4'd7:    tabela = 18'd95557;
            4'd8:    tabela = 18'd90192;
            4'd9:    tabela = 18'd85131;
            4'd10:   tabela = 18'd80353;
            4'd11:   tabela = 18'd75843;
            default: tabela = 18'd0;
        endcase
    endfunction

    logic [NR_TECLAS-1:0] tec_deb, tec_nxt;
    botao_t               st_sobe, st_desce;
    logic                 sobe_nxt, desce_nxt;
    logic                 sobe_sobe, desce_sobe;
    logic [3:0]           sel;
    logic                 alguma;

    genvar g;
    generate
        for (g = 0; g < NR_TECLAS; g++) begin : g_tecla
            debounce_lane #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_lane (
                .clk(clk), .rst(rst), .din(teclas[g]),
                .deb(tec_deb[g]), .deb_nxt(tec_nxt[g])
            );
        end
    endgenerate

    // For the buttons the FSM state is the debounced value itself.
    debounce_lane #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_sobe (
        .clk(clk), .rst(rst), .din(oct_sobe),
        .deb(st_sobe == HELD), .deb_nxt(sobe_nxt)
    );
    debounce_lane #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_desce (
        .clk(clk), .rst(rst), .din(oct_desce),
        .deb(st_desce == HELD), .deb_nxt(desce_nxt)
    );

    assign sobe_sobe  = (st_sobe  == IDLE) && sobe_nxt;
    assign desce_sobe = (st_desce == IDLE) && desce_nxt;

    always_ff @(posedge clk) begin
        if (rst) tec_deb <= '0;
        else     tec_deb <= tec_nxt;
    end

    // Octave FSM: one step per debounced rise. Simultaneous rises cancel,
    // and saturation also pins oitava at 0 when NR_OITAVAS is 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_sobe  <= IDLE;
            st_desce <= IDLE;
            oitava   <= OIT_INI;
        end else begin
            st_sobe  <= sobe_nxt  ? HELD : IDLE;
            st_desce <= desce_nxt ? HELD : IDLE;
            if (sobe_sobe && !desce_sobe && oitava != OIT_MAX)
                oitava <= oitava + 2'd1;
            else if (desce_sobe && !sobe_sobe && oitava != 2'd0)
                oitava <= oitava - 2'd1;
        end
    end

    // Lowest held index wins.
    always_comb begin
        sel    = 4'd0;
        alguma = |tec_deb;
        for (int i = NR_TECLAS - 1; i >= 0; i--)
            if (tec_deb[i]) sel = 4'(i);
    end

    // On release cp and nota_idx hold so the envelope tail keeps its pitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            cp        <= '0;
            gate      <= 1'b0;
            nova_nota <= 1'b0;
            nota_idx  <= '0;
        end else if (alguma) begin
            gate      <= 1'b1;
            nota_idx  <= sel;
            cp        <= tabela(sel) >> oitava;
            nova_nota <= !gate || (sel != nota_idx);
        end else begin
            gate      <= 1'b0;
            nova_nota <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mapeamento_tecla_cp_oct.sv
module tb_mapeamento_tecla_cp_oct;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] teclas;
    logic        oct_sobe, oct_desce;
    logic [17:0] cp;
    logic        gate, nova_nota;
    logic [3:0]  nota_idx;
    logic [1:0]  oitava;

    mapeamento_tecla_cp_oct #(
        .NR_TECLAS(12), .NR_OITAVAS(4), .OITAVA_INICIAL(0), .DEBOUNCE_CICLOS(4)
    ) dut (
        .clk(clk), .rst(rst), .teclas(teclas), .oct_sobe(oct_sobe),
        .oct_desce(oct_desce), .cp(cp), .gate(gate), .nova_nota(nova_nota),
        .nota_idx(nota_idx), .oitava(oitava)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       tag;
        logic [17:0] cp;
        logic        gate;
        logic [3:0]  idx;
        logic        nova;
        logic [1:0]  oit;
    } exp_t;

    exp_t q[$];
    exp_t e_cur;
    int   cyc    = 0;
    int   npulse = 0;
    int   total  = 0;
    int   passed = 0;
    int   p0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (nova_nota) npulse <= npulse + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    endtask

    // Scoreboard drain: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e_cur = q.pop_front();
            chk({e_cur.tag, "_cp"},   32'(cp),        32'(e_cur.cp));
            chk({e_cur.tag, "_gate"}, 32'(gate),      32'(e_cur.gate));
            chk({e_cur.tag, "_idx"},  32'(nota_idx),  32'(e_cur.idx));
            chk({e_cur.tag, "_nova"}, 32'(nova_nota), 32'(e_cur.nova));
            chk({e_cur.tag, "_oit"},  32'(oitava),    32'(e_cur.oit));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expect the given outputs after the k-th rising edge from now.
    task automatic exp_at(input int k, input string tag, input logic [17:0] c,
                          input logic g, input logic [3:0] i, input logic nv,
                          input logic [1:0] o);
        exp_t e;
        e.cyc = cyc + k; e.tag = tag; e.cp = c; e.gate = g;
        e.idx = i; e.nova = nv; e.oit = o;
        q.push_back(e);
    endtask

    task automatic press_sobe();
        oct_sobe = 1'b1; idle(8); oct_sobe = 1'b0; idle(8);
    endtask

    task automatic press_desce();
        oct_desce = 1'b1; idle(8); oct_desce = 1'b0; idle(8);
    endtask

    initial begin
        rst = 1'b1; teclas = '0; oct_sobe = 1'b0; oct_desce = 1'b0;
        idle(2);
        exp_at(1, "reset", 18'd0, 1'b0, 4'd0, 1'b0, 2'd0);
        idle(1);
        rst = 1'b0;
        idle(2);

        // 1: single key, press and release
        teclas = 12'h001; p0 = npulse;
        exp_at(6, "t1_pre",  18'd0,      1'b0, 4'd0, 1'b0, 2'd0);
        exp_at(7, "t1_on",   18'd143172, 1'b1, 4'd0, 1'b1, 2'd0);
        exp_at(8, "t1_hold", 18'd143172, 1'b1, 4'd0, 1'b0, 2'd0);
        idle(12);
        chk("t1_pulses_on", 32'(npulse - p0), 32'd1);
        teclas = 12'h000; p0 = npulse;
        exp_at(6, "t1_rel_pre", 18'd143172, 1'b1, 4'd0, 1'b0, 2'd0);
        exp_at(7, "t1_off",     18'd143172, 1'b0, 4'd0, 1'b0, 2'd0);
        exp_at(8, "t1_off2",    18'd143172, 1'b0, 4'd0, 1'b0, 2'd0);
        idle(12);
        chk("t1_pulses_off", 32'(npulse - p0), 32'd0);

        // 2: 3-cycle glitch is rejected
        teclas = 12'h001; p0 = npulse;
        for (int k = 1; k <= 12; k++)
            exp_at(k, "t2_glitch", 18'd143172, 1'b0, 4'd0, 1'b0, 2'd0);
        idle(3);
        teclas = 12'h000;
        idle(10);
        chk("t2_pulses", 32'(npulse - p0), 32'd0);

        // 3: priority and note change
        teclas = 12'h0A0;
        exp_at(7, "t3_two",  18'd107262, 1'b1, 4'd5, 1'b1, 2'd0);
        exp_at(8, "t3_two2", 18'd107262, 1'b1, 4'd5, 1'b0, 2'd0);
        idle(10);
        teclas = 12'h080; p0 = npulse;
        exp_at(6, "t3_keep",  18'd107262, 1'b1, 4'd5, 1'b0, 2'd0);
        exp_at(7, "t3_chg",   18'd95557,  1'b1, 4'd7, 1'b1, 2'd0);
        exp_at(8, "t3_after", 18'd95557,  1'b1, 4'd7, 1'b0, 2'd0);
        idle(10);
        chk("t3_pulses", 32'(npulse - p0), 32'd1);
        teclas = 12'h000;
        idle(10);

        // 4: octave shifts with saturation, legato
        teclas = 12'h200;
        exp_at(7, "t4_on", 18'd85131, 1'b1, 4'd9, 1'b1, 2'd0);
        idle(10);
        p0 = npulse;
        oct_sobe = 1'b1;
        exp_at(5, "t4_s1_pre", 18'd85131, 1'b1, 4'd9, 1'b0, 2'd0);
        exp_at(6, "t4_s1_oit", 18'd85131, 1'b1, 4'd9, 1'b0, 2'd1);
        exp_at(7, "t4_s1_cp",  18'd42565, 1'b1, 4'd9, 1'b0, 2'd1);
        idle(8); oct_sobe = 1'b0; idle(8);
        press_sobe();
        exp_at(1, "t4_s2", 18'd21282, 1'b1, 4'd9, 1'b0, 2'd2);
        idle(1);
        press_sobe(); press_sobe(); press_sobe();
        exp_at(1, "t4_sat", 18'd10641, 1'b1, 4'd9, 1'b0, 2'd3);
        idle(1);
        for (int k = 0; k < 5; k++) press_desce();
        exp_at(1, "t4_down", 18'd85131, 1'b1, 4'd9, 1'b0, 2'd0);
        idle(1);
        chk("t4_pulses", 32'(npulse - p0), 32'd0);

        // 5: simultaneous buttons cancel, long hold does not repeat
        press_sobe();
        oct_sobe = 1'b1; oct_desce = 1'b1;
        exp_at(6,   "t5_both", 18'd42565, 1'b1, 4'd9, 1'b0, 2'd1);
        exp_at(100, "t5_hold", 18'd42565, 1'b1, 4'd9, 1'b0, 2'd1);
        idle(100);
        oct_sobe = 1'b0; oct_desce = 1'b0;
        idle(10);
        exp_at(1, "t5_rel", 18'd42565, 1'b1, 4'd9, 1'b0, 2'd1);
        idle(1);
        press_sobe();
        exp_at(1, "t5_next", 18'd21282, 1'b1, 4'd9, 1'b0, 2'd2);
        idle(1);

        // 6: reset mid-press, key must re-qualify
        teclas = 12'h008;
        idle(10);
        exp_at(1, "t6_held", 18'd30098, 1'b1, 4'd3, 1'b0, 2'd2);
        idle(1);
        rst = 1'b1;
        exp_at(1, "t6_rst", 18'd0, 1'b0, 4'd0, 1'b0, 2'd0);
        idle(1);
        rst = 1'b0;
        exp_at(6, "t6_pre",  18'd0,      1'b0, 4'd0, 1'b0, 2'd0);
        exp_at(7, "t6_on",   18'd120394, 1'b1, 4'd3, 1'b1, 2'd0);
        exp_at(8, "t6_hold", 18'd120394, 1'b1, 4'd3, 1'b0, 2'd0);
        idle(10);

        idle(2);
        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
